// File: rtl/rect_drop_pkg.sv
// Shared types and defaults for the falling-rectangle scheduler.
package rect_drop_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned FLOOR_Y   = 568;
  localparam int unsigned GRAV      = 1;
  localparam int unsigned VMIN      = 2;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FALLING = 2'd1,
    RESTING = 2'd2
  } slot_phase_t;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_UPDATE = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic        [11:0] x;
    logic        [11:0] y;
    logic signed [11:0] v;
    slot_phase_t        phase;
  } slot_t;

  localparam slot_t SLOT_RESET = '{x: '0, y: '0, v: '0, phase: EMPTY};

endpackage

// File: rtl/rect_drop_sched_if.sv
// Mouse/timing inputs and per-slot draw outputs of the scheduler.
interface rect_drop_sched_if;
  logic        mouse_left;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        frame_tick;
  logic        clear;
  logic [47:0] obj_xpos;
  logic [47:0] obj_ypos;
  logic [3:0]  obj_active;
  logic        busy;

  modport master (
    output mouse_left, mouse_xpos, mouse_ypos, frame_tick, clear,
    input  obj_xpos, obj_ypos, obj_active, busy
  );

  modport slave (
    input  mouse_left, mouse_xpos, mouse_ypos, frame_tick, clear,
    output obj_xpos, obj_ypos, obj_active, busy
  );
endinterface

// File: rtl/rect_drop_phys.sv
// Combinational single-slot gravity/bounce step, shared across all slots.
module rect_drop_phys
  import rect_drop_pkg::*;
(
  input  slot_t i_slot,
  output slot_t o_slot
);

  localparam logic signed [12:0] FLOOR_S = 13'(FLOOR_Y);
  localparam logic signed [12:0] GRAV_S  = 13'(GRAV);
  localparam logic signed [12:0] VMIN_S  = 13'(VMIN);

  logic signed [12:0] w_v_next;
  logic signed [12:0] w_y_next;
  logic signed [12:0] w_v_bounce;
  logic signed [12:0] w_v_abs;
  logic signed [12:0] w_v_neg;

  always_comb begin
    w_v_next   = $signed({i_slot.v[11], i_slot.v}) + GRAV_S;
    w_y_next   = $signed({1'b0, i_slot.y}) + w_v_next;
    // Bounce keeps three quarters of the impact speed, reversed.
    w_v_bounce = -(w_v_next - (w_v_next >>> 2));
    w_v_abs    = w_v_bounce[12] ? -w_v_bounce : w_v_bounce;
    w_v_neg    = -w_v_next;

    o_slot = i_slot;
    if (i_slot.phase == FALLING) begin
      if (w_y_next >= FLOOR_S) begin
        o_slot.y = 12'(FLOOR_Y);
        if (w_v_abs < VMIN_S) begin
          o_slot.v     = '0;
          o_slot.phase = RESTING;
        end else begin
          o_slot.v = w_v_bounce[11:0];
        end
      end else if (w_y_next[12]) begin
        o_slot.y = '0;
        o_slot.v = w_v_neg[11:0];
      end else begin
        o_slot.y = w_y_next[11:0];
        o_slot.v = w_v_next[11:0];
      end
    end
  end

endmodule

// File: rtl/rect_drop_sched.sv
// Spawns rectangles on mouse clicks and steps each slot's physics once per frame.
module rect_drop_sched
  import rect_drop_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  rect_drop_sched_if.slave bus
);

  slot_t        r_slots [NUM_SLOTS];
  sched_state_t r_state;
  logic [1:0]   r_idx;
  logic         r_mouse_prev;
  logic         r_pending;
  logic [11:0]  r_px;
  logic [11:0]  r_py;

  slot_t        w_phys_in;
  slot_t        w_phys_out;
  slot_t        w_spawn;
  logic         w_click;
  logic         w_free_found;
  logic [1:0]   w_free_idx;

  assign w_click   = bus.mouse_left & ~r_mouse_prev;
  assign w_phys_in = r_slots[r_idx];

  rect_drop_phys u_phys (
    .i_slot (w_phys_in),
    .o_slot (w_phys_out)
  );

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      if (!w_free_found && r_slots[k].phase == EMPTY) begin
        w_free_found = 1'b1;
        w_free_idx   = 2'(k);
      end
    end
    w_spawn = '{x: r_px,
                y: (r_py > 12'(FLOOR_Y)) ? 12'(FLOOR_Y) : r_py,
                v: '0,
                phase: FALLING};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_SLOTS; k++) r_slots[k] <= SLOT_RESET;
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_mouse_prev <= 1'b0;
      r_pending    <= 1'b0;
      r_px         <= '0;
      r_py         <= '0;
    end else begin
      r_mouse_prev <= bus.mouse_left;
      if (bus.clear) begin
        for (int unsigned k = 0; k < NUM_SLOTS; k++) r_slots[k] <= SLOT_RESET;
        r_state   <= S_IDLE;
        r_idx     <= '0;
        r_pending <= 1'b0;
      end else begin
        if (w_click && !r_pending) begin
          r_pending <= 1'b1;
          r_px      <= bus.mouse_xpos;
          r_py      <= bus.mouse_ypos;
        end
        case (r_state)
          S_IDLE: begin
            // A pending spawn and a frame tick may both be taken in one cycle.
            if (r_pending) begin
              r_pending <= 1'b0;
              if (w_free_found) r_slots[w_free_idx] <= w_spawn;
            end
            if (bus.frame_tick) begin
              r_state <= S_UPDATE;
              r_idx   <= '0;
            end
          end
          S_UPDATE: begin
            r_slots[r_idx] <= w_phys_out;
            r_idx          <= r_idx + 2'd1;
            if (r_idx == 2'(NUM_SLOTS - 1)) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    bus.obj_xpos   = '0;
    bus.obj_ypos   = '0;
    bus.obj_active = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      bus.obj_xpos[12*k +: 12] = r_slots[k].x;
      bus.obj_ypos[12*k +: 12] = r_slots[k].y;
      bus.obj_active[k]        = (r_slots[k].phase != EMPTY);
    end
    bus.busy = (r_state == S_UPDATE);
  end

endmodule

// File: tb/tb_rect_drop_sched.sv
// Scoreboard bench for rect_drop_sched: expectations queued with stimulus, drained after each step.
module tb_rect_drop_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rect_drop_sched_if bus();

  rect_drop_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {SEL_ACT, SEL_BUSY, SEL_X, SEL_Y, SEL_XBUS, SEL_YBUS} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    int          idx;
    logic [47:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check_val(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] observe(input sel_t sel, input int idx);
    case (sel)
      SEL_ACT:  return 48'(bus.obj_active);
      SEL_BUSY: return 48'(bus.busy);
      SEL_X:    return 48'(bus.obj_xpos[12*idx +: 12]);
      SEL_Y:    return 48'(bus.obj_ypos[12*idx +: 12]);
      SEL_XBUS: return bus.obj_xpos;
      default:  return bus.obj_ypos;
    endcase
  endfunction

  task automatic expect_val(input string tag, input sel_t sel, input int idx, input logic [47:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sel, e.idx), e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic click(input logic [11:0] x, input logic [11:0] y);
    bus.mouse_xpos = x;
    bus.mouse_ypos = y;
    bus.mouse_left = 1'b1;
    step(1);
    bus.mouse_left = 1'b0;
    step(1);
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
  endtask

  // Full pass: busy for exactly four cycles, then back to idle.
  task automatic do_frame(input string tag);
    bus.frame_tick = 1'b1;
    step(1);
    bus.frame_tick = 1'b0;
    expect_val({tag, "_busy1"}, SEL_BUSY, 0, 48'd1);
    drain();
    for (int i = 0; i < 3; i++) begin
      step(1);
      expect_val({tag, "_busy"}, SEL_BUSY, 0, 48'd1);
      drain();
    end
    step(1);
    expect_val({tag, "_idle"}, SEL_BUSY, 0, 48'd0);
    drain();
  endtask

  initial begin
    logic [47:0] xb;
    bus.mouse_left = 1'b0;
    bus.mouse_xpos = '0;
    bus.mouse_ypos = '0;
    bus.frame_tick = 1'b0;
    bus.clear      = 1'b0;
    step(2);
    rst = 1'b0;
    expect_val("rst_act", SEL_ACT, 0, 48'd0);
    expect_val("rst_busy", SEL_BUSY, 0, 48'd0);
    expect_val("rst_x", SEL_XBUS, 0, 48'd0);
    expect_val("rst_y", SEL_YBUS, 0, 48'd0);
    drain();

    // single drop: y follows n(n+1)/2 until the floor bounce
    click(12'd100, 12'd0);
    expect_val("drop_act", SEL_ACT, 0, 48'b0001);
    expect_val("drop_x", SEL_X, 0, 48'd100);
    expect_val("drop_y0", SEL_Y, 0, 48'd0);
    drain();
    for (int n = 1; n <= 33; n++) begin
      do_frame("fall");
      expect_val("fall_y", SEL_Y, 0, 48'(n * (n + 1) / 2));
      drain();
    end
    do_frame("hit");
    expect_val("bounce_y", SEL_Y, 0, 48'd568);
    drain();
    do_frame("up1");
    expect_val("rise_y1", SEL_Y, 0, 48'd543);
    drain();
    do_frame("up2");
    expect_val("rise_y2", SEL_Y, 0, 48'd519);
    expect_val("rise_x", SEL_X, 0, 48'd100);
    drain();

    // fill all four slots, fifth click discarded
    pulse_clear();
    expect_val("clr_act", SEL_ACT, 0, 48'd0);
    drain();
    xb = '0;
    for (int i = 0; i < 5; i++) begin
      click(12'(11 * (i + 1)), 12'(10 * i));
      if (i < 4) xb[12*i +: 12] = 12'(11 * (i + 1));
      expect_val("fill_act", SEL_ACT, 0, (i < 4) ? 48'((1 << (i + 1)) - 1) : 48'hF);
      expect_val("fill_xbus", SEL_XBUS, 0, xb);
      drain();
      step(3);
    end
    expect_val("fill_y3", SEL_Y, 3, 48'd30);
    drain();

    // spawn clamped to floor comes to rest on first pass
    pulse_clear();
    click(12'd50, 12'd700);
    expect_val("clamp_y", SEL_Y, 0, 48'd568);
    drain();
    for (int i = 0; i < 3; i++) begin
      do_frame("rest");
      expect_val("rest_y", SEL_Y, 0, 48'd568);
      expect_val("rest_act", SEL_ACT, 0, 48'b0001);
      drain();
    end

    // click edge coincident with frame_tick
    pulse_clear();
    click(12'd200, 12'd100);
    step(2);
    bus.mouse_xpos = 12'd300;
    bus.mouse_ypos = 12'd50;
    bus.mouse_left = 1'b1;
    bus.frame_tick = 1'b1;
    step(1);
    bus.mouse_left = 1'b0;
    bus.frame_tick = 1'b0;
    expect_val("co_busy1", SEL_BUSY, 0, 48'd1);
    expect_val("co_act1", SEL_ACT, 0, 48'b0001);
    drain();
    step(1);
    expect_val("co_y0", SEL_Y, 0, 48'd101);
    expect_val("co_busy2", SEL_BUSY, 0, 48'd1);
    drain();
    step(2);
    expect_val("co_busy4", SEL_BUSY, 0, 48'd1);
    expect_val("co_act4", SEL_ACT, 0, 48'b0001);
    drain();
    step(1);
    expect_val("co_idle", SEL_BUSY, 0, 48'd0);
    expect_val("co_act5", SEL_ACT, 0, 48'b0001);
    drain();
    step(1);
    expect_val("co_spawn_act", SEL_ACT, 0, 48'b0011);
    expect_val("co_spawn_x", SEL_X, 1, 48'd300);
    expect_val("co_spawn_y", SEL_Y, 1, 48'd50);
    drain();
    step(3);
    expect_val("co_hold_y", SEL_Y, 1, 48'd50);
    drain();
    do_frame("co_next");
    expect_val("co_next_y0", SEL_Y, 0, 48'd103);
    expect_val("co_next_y1", SEL_Y, 1, 48'd51);
    drain();

    // second tick inside a pass is ignored
    bus.frame_tick = 1'b1;
    step(1);
    bus.frame_tick = 1'b0;
    step(1);
    expect_val("rep_y0", SEL_Y, 0, 48'd106);
    expect_val("rep_y1_old", SEL_Y, 1, 48'd51);
    drain();
    bus.frame_tick = 1'b1;
    step(1);
    bus.frame_tick = 1'b0;
    expect_val("rep_y1", SEL_Y, 1, 48'd53);
    drain();
    step(1);
    expect_val("rep_busy4", SEL_BUSY, 0, 48'd1);
    drain();
    step(1);
    expect_val("rep_idle", SEL_BUSY, 0, 48'd0);
    drain();
    step(1);
    expect_val("rep_noqueue", SEL_BUSY, 0, 48'd0);
    expect_val("rep_y0_once", SEL_Y, 0, 48'd106);
    expect_val("rep_y1_once", SEL_Y, 1, 48'd53);
    drain();

    // clear in the middle of a pass
    click(12'd400, 12'd0);
    expect_val("mid_act", SEL_ACT, 0, 48'b0111);
    drain();
    bus.frame_tick = 1'b1;
    step(1);
    bus.frame_tick = 1'b0;
    step(1);
    expect_val("mid_y0", SEL_Y, 0, 48'd110);
    drain();
    step(1);
    expect_val("mid_y1", SEL_Y, 1, 48'd56);
    drain();
    pulse_clear();
    expect_val("mid_clr_act", SEL_ACT, 0, 48'd0);
    expect_val("mid_clr_busy", SEL_BUSY, 0, 48'd0);
    expect_val("mid_clr_y", SEL_YBUS, 0, 48'd0);
    drain();
    step(1);
    expect_val("mid_clr_idle", SEL_BUSY, 0, 48'd0);
    drain();
    click(12'd7, 12'd9);
    expect_val("post_act", SEL_ACT, 0, 48'b0001);
    expect_val("post_x", SEL_X, 0, 48'd7);
    expect_val("post_y", SEL_Y, 0, 48'd9);
    drain();
    do_frame("post");
    expect_val("post_fall_y", SEL_Y, 0, 48'd10);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rect_drop_sched.md
# rect_drop_sched

Scheduler for up to four independently falling, bouncing rectangles spawned by mouse clicks. It owns per-slot state (position, velocity, phase) and time-multiplexes one shared physics-update unit across the slots, one slot per clock, once per frame. It sits between the mouse/timing front end and the rectangle draw stages, which consume its per-slot positions.

## Interface
- NUM_SLOTS, 4: number of rectangle slots, fixed at 4 for this revision.
- FLOOR_Y, 568: lowest allowed ypos, in pixels (600 minus the rectangle height).
- GRAV, 1: velocity increment per frame, in px/frame.
- VMIN, 2: a slot comes to rest when the post-bounce |velocity| is below this value.
- clk  in  1  system clock, 40 MHz.
- rst  in  1  synchronous, active-high reset.
- mouse_left  in  1  left button level, already synchronous to clk.
- mouse_xpos  in  12  mouse x at click time.
- mouse_ypos  in  12  mouse y at click time.
- frame_tick  in  1  one-cycle pulse, once per frame.
- clear  in  1  synchronous: empty all slots.
- obj_xpos  out  4x12 (48 packed)  per-slot x; slot k occupies bits [12k+11:12k].
- obj_ypos  out  4x12 (48 packed)  per-slot y, same packing as obj_xpos.
- obj_active  out  4  slot is FALLING or RESTING (draw it).
- busy  out  1  an update pass is in progress.

## Operation
- Per-slot phase: EMPTY, FALLING, RESTING. Each slot holds a signed 12-bit velocity (px/frame, positive = down).
- Click detect: a rising edge of mouse_left (registered previous level) sets a one-deep spawn_pending flag and latches mouse_xpos and mouse_ypos. A further edge while the flag is set is dropped.
- Spawn: applied only while the scheduler is IDLE.
  - Target is the lowest-index EMPTY slot: x = mouse_xpos, y = min(mouse_ypos, FLOOR_Y), v = 0, phase FALLING.
  - If no slot is EMPTY, the spawn is discarded.
  - spawn_pending clears in either case.
- Scheduler FSM has two states: IDLE and UPDATE with a 2-bit slot index.
  - IDLE to UPDATE (index 0) when frame_tick = 1.
  - In UPDATE, one slot is processed per cycle. After index 3 the FSM returns to IDLE.
  - frame_tick while in UPDATE is ignored; no queueing.
- Physics, shared unit, applied only to FALLING slots. EMPTY and RESTING slots are left unchanged.
  - v' = v + GRAV; y' = y + v', computed at 13 bits signed.
  - If y' >= FLOOR_Y: y = FLOOR_Y and v = -(v' - (v' >>> 2)). If that |v| < VMIN, then v = 0 and phase becomes RESTING.
  - Else if y' < 0: y = 0 and v = -v'.
  - Otherwise: y = y', v = v'.
  - x never changes after spawn.
- clear: all slots go EMPTY, spawn_pending clears, and the FSM goes to IDLE. clear has priority over everything except rst.

## Timing
- Reset: all outputs 0; all slots EMPTY with x = y = v = 0; FSM IDLE; spawn_pending 0; previous mouse level 0.
- Outputs are registered. A slot's new value is visible on the cycle after its UPDATE cycle.
- Full pass: frame_tick at cycle T puts the FSM in UPDATE from T+1 to T+4. busy is high during T+1..T+4. Slot k's outputs change at T+2+k.
- Click latency: edge at cycle C sets spawn_pending at C+1. If IDLE at C+1, the slot is written and obj_active is set at C+2. If in UPDATE, the spawn is applied on the first IDLE cycle.
- Spawn and frame_tick in the same IDLE cycle: both are accepted. The new slot is written that cycle and is updated in the pass that follows.
- rst or clear during a pass aborts it immediately. The next pass restarts at slot 0.

## Structure
- rect_drop_pkg holds:
  - slot_phase_t enum {EMPTY, FALLING, RESTING};
  - sched_state_t enum;
  - the NUM_SLOTS, FLOOR_Y, GRAV and VMIN defaults;
  - the slot record struct (x, y, v, phase).
- Sub-module rect_drop_phys: purely combinational single-slot update (slot record in, slot record out). Exactly one instance, shared across slots by the scheduler mux.

## Test plan
- Reset, then one click at (100, 0), then 34 frame_ticks.
  - obj_active = 0001.
  - After tick 33: y = 561, v = 33.
  - After tick 34: y = 568, v = -26.
- Five clicks with no ticks between them, each click separated by at least 3 idle cycles. Slots 0..3 fill in order and obj_active = 1111; the 5th click changes nothing.
- Slot spawned with y = 568, then one tick. Update gives v' = 1 and a bounce with v = -1, so the slot goes RESTING with y = 568 and v = 0. Later ticks leave it unchanged.
- Click edge in the same cycle as frame_tick, with an earlier slot FALLING. Busy is high for 4 cycles. The spawn lands on the cycle after busy falls, and the new slot keeps y = mouse_ypos until the next pass.
- frame_tick repeated at T+2 during a pass. The pass still ends at T+4, and only one update is applied per slot.
- clear asserted mid-pass with 3 slots active. The next cycle shows obj_active = 0000, busy = 0 and the FSM in IDLE. A subsequent click fills slot 0.
